// File: rtl/freq_gen_pkg.sv
// Shared constants and divider state encoding for the programmable square-wave generator.
package freq_gen_pkg;

    localparam int unsigned CLK_HZ_DEFAULT = 50_000_000;
    localparam int unsigned W_DEFAULT      = 32;
    localparam int unsigned MAX_FREQ       = CLK_HZ_DEFAULT / 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/freq_gen_div.sv
// Restoring divider, one quotient bit per clock; quotient is held stable while done is high.
//   state   | meaning
//   ST_IDLE | waiting for start
//   ST_DIV  | W shift/subtract steps, MSB of dividend first
//   ST_DONE | quotient valid for one cycle
module freq_gen_div
    import freq_gen_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W:0]   divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient
);

    localparam int unsigned   CW        = $clog2(W + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

    div_state_e    state_q, state_d;
    logic [CW-1:0] step_q, step_d;
    logic [W:0]    rem_q, rem_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W:0]    dvs_q, dvs_d;
    logic [W+1:0]  rem_shift;
    logic          rem_ge;

    always_comb begin
        rem_shift = {rem_q, quo_q[W-1]};
        rem_ge    = rem_shift >= {1'b0, dvs_q};
        state_d   = state_q;
        step_d    = step_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_DIV;
                    step_d  = LAST_STEP;
                    rem_d   = '0;
                    quo_d   = dividend;
                    dvs_d   = divisor;
                end
            end
            ST_DIV: begin
                // Remainder stays below the divisor, so W+1 bits always hold it.
                rem_d  = rem_ge ? (W + 1)'(rem_shift - {1'b0, dvs_q}) : rem_shift[W:0];
                quo_d  = {quo_q[W-2:0], rem_ge};
                step_d = step_q - CW'(1);
                if (step_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign quotient = quo_q;

endmodule

// File: rtl/freq_gen.sv
// Programmable 50% duty square-wave generator; the half-period comes from CLK_HZ / (2*freq_hz)
// and a new value only takes over at a toggle boundary so no runt pulses appear.
module freq_gen
    import freq_gen_pkg::*;
#(
    parameter int unsigned CLK_HZ = CLK_HZ_DEFAULT,
    parameter int unsigned W      = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] freq_hz,
    input  logic         freq_load,
    input  logic         enable,
    output logic         fm_out,
    output logic         busy,
    output logic         freq_err,
    output logic [W-1:0] half_period
);

    localparam logic [W-1:0] MAX_F    = W'(CLK_HZ / 2);
    localparam logic [W-1:0] DIVIDEND = W'(CLK_HZ);

    logic         accept, range_bad, div_start, div_busy, div_done;
    logic [W-1:0] div_q;
    logic         freq_err_q, freq_err_d;
    logic         pending_q, pending_d;
    logic [W-1:0] shadow_q, shadow_d;
    logic [W-1:0] hp_q, hp_d;
    logic [W-1:0] hcnt_q, hcnt_d;
    logic         fm_q, fm_d;
    logic         pend_eff, apply;
    logic [W-1:0] shadow_eff;

    // f > floor(CLK_HZ/2) is the same test as 2*f > CLK_HZ without needing a wider compare.
    assign accept    = freq_load & ~div_busy;
    assign range_bad = (freq_hz == '0) || (freq_hz > MAX_F);
    assign div_start = accept & ~range_bad;

    freq_gen_div #(.W(W)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (DIVIDEND),
        .divisor  ({freq_hz, 1'b0}),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_q)
    );

    always_comb begin
        freq_err_d = freq_err_q;
        if (accept) begin
            freq_err_d = range_bad;
        end
        // A result finishing on a toggle edge is used at that very toggle.
        pend_eff   = pending_q | div_done;
        shadow_eff = div_done ? div_q : shadow_q;
        shadow_d   = shadow_eff;
        apply      = 1'b0;
        fm_d       = fm_q;
        hcnt_d     = hcnt_q;
        hp_d       = hp_q;
        if (!enable || (hp_q == '0)) begin
            fm_d   = 1'b0;
            hcnt_d = '0;
            apply  = pend_eff;
        end else if (hcnt_q == hp_q - W'(1)) begin
            fm_d   = ~fm_q;
            hcnt_d = '0;
            apply  = pend_eff;
        end else begin
            hcnt_d = hcnt_q + W'(1);
        end
        if (apply) begin
            hp_d = shadow_eff;
        end
        pending_d = pend_eff & ~apply;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            freq_err_q <= 1'b0;
            pending_q  <= 1'b0;
            shadow_q   <= '0;
            hp_q       <= '0;
            hcnt_q     <= '0;
            fm_q       <= 1'b0;
        end else begin
            freq_err_q <= freq_err_d;
            pending_q  <= pending_d;
            shadow_q   <= shadow_d;
            hp_q       <= hp_d;
            hcnt_q     <= hcnt_d;
            fm_q       <= fm_d;
        end
    end

    assign fm_out      = fm_q;
    assign busy        = div_busy;
    assign freq_err    = freq_err_q;
    assign half_period = hp_q;

endmodule
